traffic_light_multi: RTL and testbench

- Parametrised successor to the single-approach traffic light controller. It drives NUM_PHASES conflicting approaches round-robin: one approach is green or yellow while all others are red.
- Adds a tick-based time base, parametrised durations, an all-red clearance interval, a flashing-yellow attention mode, and a safe forced-red that always passes through yellow.
- Sits between the intersection time-base/operator inputs and the lamp drivers.

---
 rtl/traffic_light_multi_if.sv | 23 ++
 rtl/traffic_light_multi.sv | 98 +++++++++
 tb/tb_traffic_light_multi.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/traffic_light_multi_if.sv
// traffic_light_multi_if: operator/time-base requests in, lamp and status outputs back
interface traffic_light_multi_if #(
    parameter int NUM_PHASES = 2
);
    localparam int PW = $clog2(NUM_PHASES);
    logic                    tick;
    logic                    preset;
    logic                    preset_add;
    logic                    preferential;
    logic                    attention;
    logic                    force_red;
    logic [3*NUM_PHASES-1:0] leds;
    logic [PW-1:0]           active_phase;
    logic                    cycle_done;
    modport master (
        output tick, preset, preset_add, preferential, attention, force_red,
        input  leds, active_phase, cycle_done
    );
    modport slave (
        input  tick, preset, preset_add, preferential, attention, force_red,
        output leds, active_phase, cycle_done
    );
endinterface

// File: rtl/traffic_light_multi.sv
// traffic_light_multi: round-robin multi-approach signal controller with clearance, flash and forced red
module traffic_light_multi #(
    parameter int NUM_PHASES  = 2,
    parameter int TIMER_W     = 8,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int EXTRA_STEP  = 10,
    parameter int EXTRA_MAX   = 60
) (
    input logic                  clk,
    input logic                  rst,
    traffic_light_multi_if.slave bus
);
    localparam int PW = $clog2(NUM_PHASES);

    typedef enum logic [2:0] {
        S_INIT, S_PRESET, S_GREEN, S_YELLOW, S_ALLRED, S_FLASH, S_FORCED
    } state_t;

    state_t                  state, state_nx;
    logic [TIMER_W-1:0]      timer, extra, dwell, green_dwell;
    logic [TIMER_W:0]        green_sum, extra_sum;
    logic [PW-1:0]           phase, phase_inc;
    logic [3*NUM_PHASES-1:0] leds;
    logic                    flash, pend_force, pend_attn, add_q, cycle_done, expire;

    // green dwell widened by one bit so a large extension saturates instead of wrapping
    assign green_sum   = (TIMER_W+1)'(GREEN_TIME) + {1'b0, extra};
    assign green_dwell = green_sum[TIMER_W] ? '1 : green_sum[TIMER_W-1:0];
    assign extra_sum   = {1'b0, extra} + (TIMER_W+1)'(EXTRA_STEP);
    assign phase_inc   = (phase == PW'(NUM_PHASES-1)) ? '0 : phase + PW'(1);
    assign dwell       = state == S_GREEN  ? green_dwell :
                         state == S_YELLOW ? TIMER_W'(YELLOW_TIME) : TIMER_W'(ALLRED_TIME);
    assign expire      = bus.tick && timer == dwell - TIMER_W'(1);

    // next state; force_red outranks attention, and yellow is never cut short
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:   state_nx = bus.preset ? S_PRESET : S_GREEN;
            S_PRESET: state_nx = bus.preset ? S_PRESET : S_GREEN;
            S_GREEN:  state_nx = (bus.force_red || bus.attention || expire) ? S_YELLOW : S_GREEN;
            S_YELLOW: state_nx = !expire ? S_YELLOW :
                                 (pend_force || bus.force_red) ? S_FORCED :
                                 (pend_attn || bus.attention) ? S_FLASH : S_ALLRED;
            S_ALLRED: state_nx = bus.force_red ? S_FORCED : bus.attention ? S_FLASH :
                                 expire ? S_GREEN : S_ALLRED;
            S_FLASH:  state_nx = bus.force_red ? S_FORCED : bus.attention ? S_FLASH : S_ALLRED;
            S_FORCED: state_nx = bus.force_red ? S_FORCED : S_ALLRED;
            default:  state_nx = S_INIT;
        endcase
    end

    // state register, dwell timer, phase pointer, green extension and pending yellow exits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INIT;
            timer      <= '0;
            extra      <= '0;
            phase      <= '0;
            flash      <= 1'b0;
            cycle_done <= 1'b0;
            pend_force <= 1'b0;
            pend_attn  <= 1'b0;
            add_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= (state_nx != state || state == S_FORCED) ? '0 : timer + TIMER_W'(bus.tick);
            add_q      <= bus.preset_add;
            pend_force <= state_nx == S_YELLOW && (pend_force || bus.force_red);
            pend_attn  <= state_nx == S_YELLOW && (pend_attn || bus.attention);
            flash      <= state_nx != S_FLASH ? 1'b0 : state != S_FLASH ? 1'b1 : flash ^ bus.tick;
            cycle_done <= state == S_ALLRED && state_nx == S_GREEN && phase_inc == '0;
            if (state == S_INIT || state == S_PRESET)
                phase <= '0;
            else if (state == S_ALLRED && state_nx == S_GREEN)
                phase <= phase_inc;
            if (state == S_INIT)
                extra <= bus.preferential ? TIMER_W'(EXTRA_STEP) : '0;
            else if (state == S_PRESET && bus.preset_add && !add_q)
                extra <= extra_sum > (TIMER_W+1)'(EXTRA_MAX) ? TIMER_W'(EXTRA_MAX) : extra_sum[TIMER_W-1:0];
        end
    end

    // Moore lamp decode: only the active approach leaves red, except flash where all blink yellow
    always_comb begin
        leds = '0;
        for (int p = 0; p < NUM_PHASES; p++)
            leds[3*p +: 3] = state == S_FLASH ? {1'b0, flash, 1'b0} :
                             (PW'(p) == phase && state == S_GREEN)  ? 3'b100 :
                             (PW'(p) == phase && state == S_YELLOW) ? 3'b010 : 3'b001;
    end

    assign bus.leds         = leds;
    assign bus.active_phase = phase;
    assign bus.cycle_done   = cycle_done;
endmodule

// File: tb/tb_traffic_light_multi.sv
// tb_traffic_light_multi: randomized run against a countdown-based reference of the signal plan
module tb_traffic_light_multi;
    localparam int NP = 3;
    localparam int GT = 30, YT = 3, AT = 2, ES = 10, EM = 60, TMAX = 255;
    localparam int M_INIT = 0, M_PRESET = 1, M_GREEN = 2, M_YELLOW = 3, M_ALLRED = 4, M_FLASH = 5, M_FORCED = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int mode, rem, m_extra, m_phase;
    bit m_flash, m_cd, pf, pa, add_prev;

    traffic_light_multi_if #(.NUM_PHASES(NP)) bus();
    traffic_light_multi #(.NUM_PHASES(NP)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int dwell_of(input int m);
        if (m == M_GREEN) return (GT + m_extra > TMAX) ? TMAX : GT + m_extra;
        if (m == M_YELLOW) return YT;
        if (m == M_ALLRED) return AT;
        return 0;
    endfunction

    function automatic logic [3*NP-1:0] exp_leds();
        logic [3*NP-1:0] v;
        for (int p = 0; p < NP; p++) begin
            if (mode == M_FLASH) v[3*p +: 3] = {1'b0, m_flash, 1'b0};
            else if (p == m_phase && mode == M_GREEN) v[3*p +: 3] = 3'b100;
            else if (p == m_phase && mode == M_YELLOW) v[3*p +: 3] = 3'b010;
            else v[3*p +: 3] = 3'b001;
        end
        return v;
    endfunction

    task automatic model_reset();
        mode = M_INIT; rem = 0; m_extra = 0; m_phase = 0;
        m_flash = 0; m_cd = 0; pf = 0; pa = 0; add_prev = 0;
    endtask

    task automatic model_step();
        int nm = mode;
        bit done = bus.tick && rem == 1;
        bit cd = 0;
        case (mode)
            M_INIT: begin
                m_extra = bus.preferential ? ES : 0;
                m_phase = 0;
                nm = bus.preset ? M_PRESET : M_GREEN;
            end
            M_PRESET: begin
                if (bus.preset_add && !add_prev) m_extra = (m_extra + ES > EM) ? EM : m_extra + ES;
                if (!bus.preset) nm = M_GREEN;
            end
            M_GREEN: if (bus.force_red || bus.attention || done) begin
                nm = M_YELLOW; pf = bus.force_red; pa = bus.attention;
            end
            M_YELLOW: begin
                pf = pf | bus.force_red;
                pa = pa | bus.attention;
                if (done) begin
                    nm = pf ? M_FORCED : pa ? M_FLASH : M_ALLRED;
                    pf = 0; pa = 0;
                end
            end
            M_ALLRED: begin
                if (bus.force_red) nm = M_FORCED;
                else if (bus.attention) nm = M_FLASH;
                else if (done) begin
                    nm = M_GREEN;
                    m_phase = (m_phase + 1) % NP;
                    cd = (m_phase == 0);
                end
            end
            M_FLASH: begin
                if (bus.force_red) nm = M_FORCED;
                else if (!bus.attention) nm = M_ALLRED;
            end
            M_FORCED: if (!bus.force_red) nm = M_ALLRED;
            default: nm = M_INIT;
        endcase
        if (nm == M_FLASH) m_flash = (mode != M_FLASH) ? 1'b1 : m_flash ^ bus.tick;
        else m_flash = 0;
        if (nm != mode) rem = dwell_of(nm);
        else if (bus.tick) rem--;
        add_prev = bus.preset_add;
        m_cd = cd;
        mode = nm;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("leds", 32'(bus.leds), 32'(exp_leds()));
        check("active_phase", 32'(bus.active_phase), 32'(m_phase));
        check("cycle_done", 32'(bus.cycle_done), 32'(m_cd));
        @(negedge clk);
    endtask

    initial begin
        int preset_len, density;
        bit quiet;
        bus.tick = 0; bus.preset = 0; bus.preset_add = 0;
        bus.preferential = 0; bus.attention = 0; bus.force_red = 0;
        @(negedge clk);
        for (int seg = 0; seg < 8; seg++) begin
            #2 rst = 1'b0;
            model_reset();
            #1;
            check("rst_leds", 32'(bus.leds), 32'(exp_leds()));
            check("rst_phase", 32'(bus.active_phase), 32'(0));
            check("rst_cycle_done", 32'(bus.cycle_done), 32'(0));
            @(negedge clk);
            quiet = (seg == 0);
            density = quiet ? 1 : $urandom_range(4, 1);
            bus.preferential = quiet ? 1'b0 : 1'($urandom_range(1, 0));
            bus.preset = quiet ? 1'b0 : 1'($urandom_range(1, 0));
            bus.preset_add = 0; bus.force_red = 0; bus.attention = 0;
            preset_len = bus.preset ? $urandom_range(40, 5) : 0;
            rst = 1'b1;
            for (int c = 0; c < 2500; c++) begin
                bus.tick = ($urandom_range(density - 1, 0) == 0);
                if (c < preset_len) bus.preset_add = 1'($urandom_range(1, 0));
                else begin bus.preset = 0; bus.preset_add = 0; end
                if (!quiet) begin
                    if (bus.force_red ? $urandom_range(29, 0) == 0 : $urandom_range(399, 0) == 0) bus.force_red = ~bus.force_red;
                    if (bus.attention ? $urandom_range(39, 0) == 0 : $urandom_range(299, 0) == 0) bus.attention = ~bus.attention;
                end
                cycle();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
